// File: rtl/exp_gate_bist.sv
// Exerciser for a 10-input expander gate: sweeps all input vectors, checks XBAR == ~X, MISR-compacts {XBAR,X}.
// Each vector takes SETTLE+1 cycles; START is accepted only in IDLE and ignored otherwise.
module exp_gate_bist #(
  parameter int unsigned              N_IN       = 10,
  parameter int unsigned              SETTLE     = 2,
  parameter int unsigned              SIG_W      = 16,
  parameter logic [SIG_W-1:0]         POLY       = 16'h1021,
  parameter logic [SIG_W-1:0]         GOLDEN_SIG = 16'h0000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        X,
  input  logic                        XBAR,
  output logic [N_IN-1:0]             VEC,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        PASS,
  output logic [7:0]                  ERR_CNT,
  output logic [SIG_W-1:0]            SIGNATURE
);

  localparam int unsigned WAIT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          err_q, err_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic [SIG_W-1:0]    sig_next;

  // Galois-style MISR step with the gate pair folded into the two LSBs
  always_comb begin
    sig_next = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-2){1'b0}}, XBAR, X};
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    done_d  = done_q;
    err_d   = err_q;
    sig_d   = sig_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = APPLY;
          vec_d   = '0;
          wait_d  = '0;
          done_d  = 1'b0;
          err_d   = '0;
          sig_d   = '0;
        end
      end
      APPLY: begin
        if (wait_q == WAIT_LAST) begin
          state_d = SAMPLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      SAMPLE: begin
        sig_d = sig_next;
        if ((X == XBAR) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        // Last vector ends the sweep; VEC never wraps back to zero.
        if (&vec_q) begin
          state_d = FIN;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          wait_d  = '0;
          state_d = APPLY;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == SAMPLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sig_q   <= sig_d;
    end
  end

  assign VEC       = vec_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR_CNT   = err_q;
  assign SIGNATURE = sig_q;
  assign PASS      = done_q && (err_q == 8'd0) && (sig_q == GOLDEN_SIG);

endmodule

// File: tb/tb_exp_gate_bist.sv
// Bench for exp_gate_bist: behavioural expander gate with selectable faults, software MISR reference.
module tb_exp_gate_bist;

  localparam int MODE_GOOD   = 0;
  localparam int MODE_SINGLE = 1;
  localparam int MODE_STUCK  = 2;

  // Good gate is an AND-OR expander: A&B&C | D&E | F&G&H | I&J; returns {xbar, x}
  function automatic logic [1:0] gate_pair(input int mode, input logic [9:0] v);
    logic x;
    x = (v[9] & v[8] & v[7]) | (v[6] & v[5]) | (v[4] & v[3] & v[2]) | (v[1] & v[0]);
    if (mode == MODE_STUCK) return 2'b00;
    if (mode == MODE_SINGLE && v == 10'h1A5) return {x, x};
    return {~x, x};
  endfunction

  function automatic logic [15:0] model_sig(input int mode);
    logic [15:0] s;
    logic [1:0]  p;
    s = 16'h0000;
    for (int v = 0; v < 1024; v++) begin
      p = gate_pair(mode, 10'(v));
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, p};
    end
    return s;
  endfunction

  function automatic logic [7:0] model_err(input int mode);
    int n;
    logic [1:0] p;
    n = 0;
    for (int v = 0; v < 1024; v++) begin
      p = gate_pair(mode, 10'(v));
      if (p[1] == p[0]) n++;
    end
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  localparam logic [15:0] GOLDEN = model_sig(MODE_GOOD);

  typedef struct {
    logic [7:0]  err;
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic        x_in;
  logic        xbar_in;
  logic [9:0]  vec;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [15:0] signature;
  int          gmode;
  int          checks;
  int          errors;

  exp_gate_bist #(
    .N_IN(10), .SETTLE(2), .SIG_W(16), .POLY(16'h1021), .GOLDEN_SIG(GOLDEN)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .X(x_in), .XBAR(xbar_in),
    .VEC(vec), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err_cnt), .SIGNATURE(signature)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    logic [1:0] p;
    p       = gate_pair(gmode, vec);
    x_in    = p[0];
    xbar_in = p[1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] avoid);
    checks++;
    assert (obs !== avoid) else begin
      errors++;
      $error("FAIL %s observed=%0h must differ from %0h", tag, obs, avoid);
    end
  endtask

  // Edge 1 is the edge that samples START; returns the edge count at which DONE is first seen.
  task automatic sweep(input int mode, input int poke_vec, output int done_edge, output int busy_cnt);
    exp_t e;
    bit   poked;
    gmode  = mode;
    e.err  = model_err(mode);
    e.sig  = model_sig(mode);
    e.pass = (e.err == 8'd0) && (e.sig == GOLDEN);
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start     = 1'b0;
    done_edge = 1;
    busy_cnt  = busy ? 1 : 0;
    poked     = 1'b0;
    while (!done && done_edge < 4000) begin
      if (start) start = 1'b0;
      if (poke_vec >= 0 && !poked && busy && vec == 10'(poke_vec)) begin
        start = 1'b1;
        poked = 1'b1;
      end
      tick();
      done_edge++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
  endtask

  task automatic score(input string tag, input int done_edge, input int busy_cnt);
    exp_t e;
    chk({tag, "_done_edge"}, 32'(done_edge), 32'd3074);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd3072);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_vec_last"}, 32'(vec), 32'h3FF);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
      chk({tag, "_signature"}, 32'(signature), 32'(e.sig));
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
    end
  endtask

  initial begin
    int de;
    int bc;
    int n;
    checks = 0;
    errors = 0;
    gmode  = MODE_GOOD;
    start  = 1'b0;
    rst    = 1'b1;

    repeat (3) tick();
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    rst = 1'b0;
    tick();

    sweep(MODE_GOOD, -1, de, bc);
    score("good", de, bc);
    chk("good_sig_golden", 32'(signature), 32'(GOLDEN));
    repeat (3) tick();
    chk("good_done_held", 32'(done), 32'd1);
    chk("good_pass_held", 32'(pass), 32'd1);

    sweep(MODE_SINGLE, -1, de, bc);
    score("single", de, bc);
    chk("single_err_one", 32'(err_cnt), 32'd1);
    chk_ne("single_sig_bad", 32'(signature), 32'(GOLDEN));
    chk("single_pass_low", 32'(pass), 32'd0);

    sweep(MODE_STUCK, -1, de, bc);
    score("stuck", de, bc);
    chk("stuck_err_sat", 32'(err_cnt), 32'd255);
    chk("stuck_pass_low", 32'(pass), 32'd0);

    // Restart from DONE, then abort that run with reset at VEC==100
    gmode = MODE_GOOD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_err", 32'(err_cnt), 32'd0);
    chk("restart_vec", 32'(vec), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_pass", 32'(pass), 32'd0);
    n = 0;
    while (vec != 10'd100 && n < 1000) begin
      tick();
      n++;
    end
    chk("midrst_reach_vec", 32'(vec), 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vec", 32'(vec), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err_cnt), 32'd0);
    chk("midrst_sig", 32'(signature), 32'd0);
    repeat (4) tick();
    chk("midrst_no_done", 32'(done), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Fresh sweep with a stray START while busy at VEC==50
    sweep(MODE_GOOD, 50, de, bc);
    score("poke", de, bc);
    chk("poke_pass", 32'(pass), 32'd1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
